// File: rtl/div_unit_64_if.sv
// Request/response bundle between the issue logic and the divide unit.
interface div_unit_64_if #(
   parameter int XLEN = 64
);
   logic            start;
   logic            flush;
   logic [1:0]      op;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (
      output start, flush, op, a, b,
      input  busy, done, result
   );

   modport slave (
      input  start, flush, op, a, b,
      output busy, done, result
   );
endinterface

// File: rtl/div_unit_64.sv
// RV64M DIV/DIVU/REM/REMU: radix-2 restoring divider,
// one quotient bit per clock, sign fix-up in a final cycle.
module div_unit_64 #(
   parameter int XLEN = 64
) (
   input  logic        clk,
   input  logic        reset,
   div_unit_64_if.slave io
);
   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t          state_q;
   logic [XLEN-1:0] rem_q;
   logic [XLEN-1:0] quo_q;
   logic [XLEN-1:0] dvs_q;
   logic [XLEN-1:0] result_q;
   logic [CW-1:0]   cnt_q;
   logic            qneg_q;
   logic            rneg_q;
   logic            isrem_q;
   logic            done_q;

   logic            sgn_op;
   logic            a_neg;
   logic            b_neg;
   logic            special;
   logic [XLEN-1:0] a_mag;
   logic [XLEN-1:0] b_mag;
   logic [XLEN-1:0] spec_res;
   logic [XLEN:0]   shifted;
   logic            ge;
   logic [XLEN-1:0] diff;
   logic [XLEN-1:0] q_fix;
   logic [XLEN-1:0] r_fix;

   always_comb begin
      sgn_op  = ~io.op[0];
      a_neg   = sgn_op & io.a[XLEN-1];
      b_neg   = sgn_op & io.b[XLEN-1];
      a_mag   = a_neg ? -io.a : io.a;
      b_mag   = b_neg ? -io.b : io.b;
      special = (io.b == '0) |
                (sgn_op & (io.a == MIN_NEG) & (io.b == '1));
      // Divide-by-zero and signed overflow use the ISA-defined results
      if (io.b == '0)
         spec_res = io.op[1] ? io.a : '1;
      else
         spec_res = io.op[1] ? '0 : io.a;
      shifted = {rem_q, quo_q[XLEN-1]};
      ge      = shifted >= {1'b0, dvs_q};
      diff    = shifted[XLEN-1:0] - dvs_q;
      q_fix   = qneg_q ? -quo_q : quo_q;
      r_fix   = rneg_q ? -rem_q : rem_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         isrem_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (io.flush) begin
            state_q <= IDLE;
         end else begin
            unique case (state_q)
               IDLE: begin
                  if (io.start) begin
                     if (special) begin
                        result_q <= spec_res;
                        done_q   <= 1'b1;
                     end else begin
                        rem_q   <= '0;
                        quo_q   <= a_mag;
                        dvs_q   <= b_mag;
                        qneg_q  <= a_neg ^ b_neg;
                        rneg_q  <= a_neg;
                        isrem_q <= io.op[1];
                        cnt_q   <= CW'(XLEN - 1);
                        state_q <= CALC;
                     end
                  end
               end
               CALC: begin
                  // Dividend bits shift out of quo_q as quotient bits shift in
                  if (ge) begin
                     rem_q <= diff;
                     quo_q <= {quo_q[XLEN-2:0], 1'b1};
                  end else begin
                     rem_q <= shifted[XLEN-1:0];
                     quo_q <= {quo_q[XLEN-2:0], 1'b0};
                  end
                  cnt_q <= cnt_q - 1'b1;
                  if (cnt_q == '0)
                     state_q <= FIX;
               end
               FIX: begin
                  result_q <= isrem_q ? r_fix : q_fix;
                  done_q   <= 1'b1;
                  state_q  <= IDLE;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign io.busy   = (state_q != IDLE);
   assign io.done   = done_q;
   assign io.result = result_q;
endmodule
